sincos_interp_pipe: RTL and testbench

//  Parametrised, fully pipelined sine/cosine generator for the Box-Muller Gaussian path.
//  - Takes an unsigned phase word and returns signed sin and cos samples.
//  - Each sample is linearly interpolated between adjacent entries of one full-cycle sine table.
//  - cos uses the same table at a quarter-cycle address offset.
//  - Sits between the uniform-phase generator and the sqrt(-2ln u) multiplier.
//  - Streams one result per clock with valid/ready backpressure.

---
 rtl/sincos_pkg.sv | 62 ++++++
 rtl/sincos_lut_rom.sv | 45 ++++
 rtl/sincos_interp_pipe.sv | 163 ++++++++++++++++
 tb/tb_sincos_interp_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_pkg.sv
// Shared constants and helpers for the interpolating sine/cosine pipeline.
// The sine table is computed at elaboration from sin_entry(), so no table
// image has to travel with the RTL.
package sincos_pkg;

  localparam int unsigned DEF_PHASE_W = 32;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_FRAC_W  = 6;
  localparam int unsigned DEF_DATA_W  = 16;

  // pi in unsigned Q4.60, used by the elaboration-time table builder
  localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

  // Quarter-cycle address offset that turns a sine lookup into cosine
  function automatic int unsigned quarter_off(input int unsigned addr_w);
    return 32'd1 << (addr_w - 2);
  endfunction

  // Half-LSB constant added before the fraction shift (round half up)
  function automatic int round_half(input int unsigned frac_w);
    return 1 << (frac_w - 1);
  endfunction

  // Clamp a wide signed value into the signed data_w range
  function automatic logic signed [63:0] sat_data(input logic signed [63:0] x,
                                                  input int unsigned data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // round((2^(data_w-1)-1) * sin(2*pi*k / 2^addr_w)), half away from zero.
  // Folded to the first quadrant, then a Q60 Taylor series; integer-only so
  // it evaluates as a constant function in every tool.
  function automatic int sin_entry(input int unsigned k, input int unsigned addr_w,
                                   input int unsigned data_w);
    int unsigned n_full, quarter, kk, quad, off, r;
    logic signed [127:0] x, x2, term, acc, amp, scaled;
    n_full  = 32'd1 << addr_w;
    quarter = n_full >> 2;
    kk      = k % n_full;
    quad    = kk / quarter;
    off     = kk % quarter;
    r       = quad[0] ? (quarter - off) : off;
    x       = (PI_Q60 * $signed(128'(r))) >>> (addr_w - 1);
    x2      = (x * x) >>> 60;
    term    = x;
    acc     = x;
    for (int unsigned n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 60) / $signed(128'(2 * n * (2 * n + 1))));
      acc  = acc + term;
    end
    amp    = $signed(128'((32'd1 << (data_w - 1)) - 32'd1));
    scaled = (acc * amp + (128'sd1 <<< 59)) >>> 60;
    return quad[1] ? -int'(scaled) : int'(scaled);
  endfunction

endpackage

// File: rtl/sincos_lut_rom.sv
// Full-cycle sine ROM with two independent registered read ports.
module sincos_lut_rom
  import sincos_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              en_a,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              en_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] table_w [DEPTH];
  logic [DATA_W-1:0] q_a_d, q_a_q;
  logic [DATA_W-1:0] q_b_d, q_b_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    localparam logic [DATA_W-1:0] ENTRY = DATA_W'(sin_entry(k, ADDR_W, DATA_W));
    assign table_w[k] = ENTRY;
  end

  // Each port reads only when enabled, otherwise holds its last word
  always_comb begin
    q_a_d = q_a_q;
    q_b_d = q_b_q;
    if (en_a) q_a_d = table_w[addr_a];
    if (en_b) q_b_d = table_w[addr_b];
  end

  // Output registers give the 1-cycle read latency
  always_ff @(posedge clk) begin
    q_a_q <= q_a_d;
    q_b_q <= q_b_d;
  end

  assign q_a = q_a_q;
  assign q_b = q_b_q;

endmodule

// File: rtl/sincos_interp_pipe.sv
// Pipelined sin/cos generator: table lookup plus linear interpolation,
// one result per clock, whole pipe stalls on output backpressure.
module sincos_interp_pipe
  import sincos_pkg::*;
#(
  parameter int unsigned PHASE_W = DEF_PHASE_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned FRAC_W  = DEF_FRAC_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PHASE_W-1:0]       in_phase,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sin,
  output logic signed [DATA_W-1:0] out_cos
);

  localparam int unsigned DW = DATA_W + 1;
  localparam int unsigned PW = DATA_W + FRAC_W + 2;
  localparam logic [ADDR_W-1:0]    QOFF = ADDR_W'(quarter_off(ADDR_W));
  localparam logic signed [PW-1:0] RND  = PW'(round_half(FRAC_W));

  logic                en;
  logic [ADDR_W-1:0]   idx;
  logic [FRAC_W-1:0]   frac;
  logic                unused_phase_bits;

  // S0: addresses and fraction
  logic                s0_valid_d, s0_valid_q;
  logic [ADDR_W-1:0]   sa0_d, sa0_q, sa1_d, sa1_q, ca0_d, ca0_q, ca1_d, ca1_q;
  logic [FRAC_W-1:0]   s0_frac_d, s0_frac_q;
  // S1: ROM words (registered inside the ROMs)
  logic [DATA_W-1:0]   s1_sin0, s1_sin1, s1_cos0, s1_cos1;
  logic                s1_valid_d, s1_valid_q;
  logic [FRAC_W-1:0]   s1_frac_d, s1_frac_q;
  // S2: base sample and slope
  logic                s2_valid_d, s2_valid_q;
  logic [FRAC_W-1:0]   s2_frac_d, s2_frac_q;
  logic signed [DATA_W-1:0] s2_sin_base_d, s2_sin_base_q, s2_cos_base_d, s2_cos_base_q;
  logic signed [DW-1:0]     s2_sin_diff_d, s2_sin_diff_q, s2_cos_diff_d, s2_cos_diff_q;
  // S3: scaled slope
  logic                s3_valid_d, s3_valid_q;
  logic signed [DATA_W-1:0] s3_sin_base_d, s3_sin_base_q, s3_cos_base_d, s3_cos_base_q;
  logic signed [PW-1:0]     s3_sin_prod_d, s3_sin_prod_q, s3_cos_prod_d, s3_cos_prod_q;
  // S4: output registers
  logic                out_valid_d, out_valid_q;
  logic signed [DATA_W-1:0] out_sin_d, out_sin_q, out_cos_d, out_cos_q;
  logic signed [PW-1:0]     sin_sum, cos_sum;

  assign idx  = in_phase[PHASE_W-1 -: ADDR_W];
  assign frac = in_phase[PHASE_W-ADDR_W-1 -: FRAC_W];
  assign unused_phase_bits = ^in_phase;

  sincos_lut_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sin_rom (
    .clk   (clk),
    .en_a  (en),
    .addr_a(sa0_q),
    .q_a   (s1_sin0),
    .en_b  (en),
    .addr_b(sa1_q),
    .q_b   (s1_sin1)
  );

  sincos_lut_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cos_rom (
    .clk   (clk),
    .en_a  (en),
    .addr_a(ca0_q),
    .q_a   (s1_cos0),
    .en_b  (en),
    .addr_b(ca1_q),
    .q_b   (s1_cos1)
  );

  // Global stall: every stage advances together or holds together
  always_comb begin
    en       = !out_valid_q || out_ready;
    in_ready = en;
  end

  // Next-state for all pipeline stages; defaults hold for the stall case
  always_comb begin
    s0_valid_d = s0_valid_q;  sa0_d = sa0_q;  sa1_d = sa1_q;
    ca0_d = ca0_q;  ca1_d = ca1_q;  s0_frac_d = s0_frac_q;
    s1_valid_d = s1_valid_q;  s1_frac_d = s1_frac_q;
    s2_valid_d = s2_valid_q;  s2_frac_d = s2_frac_q;
    s2_sin_base_d = s2_sin_base_q;  s2_cos_base_d = s2_cos_base_q;
    s2_sin_diff_d = s2_sin_diff_q;  s2_cos_diff_d = s2_cos_diff_q;
    s3_valid_d = s3_valid_q;
    s3_sin_base_d = s3_sin_base_q;  s3_cos_base_d = s3_cos_base_q;
    s3_sin_prod_d = s3_sin_prod_q;  s3_cos_prod_d = s3_cos_prod_q;
    out_valid_d = out_valid_q;  out_sin_d = out_sin_q;  out_cos_d = out_cos_q;

    sin_sum = PW'(s3_sin_base_q) + ((s3_sin_prod_q + RND) >>> FRAC_W);
    cos_sum = PW'(s3_cos_base_q) + ((s3_cos_prod_q + RND) >>> FRAC_W);

    if (en) begin
      s0_valid_d = in_valid;
      if (in_valid) begin
        sa0_d     = idx;
        sa1_d     = idx + ADDR_W'(1);
        ca0_d     = idx + QOFF;
        ca1_d     = idx + QOFF + ADDR_W'(1);
        s0_frac_d = frac;
      end

      s1_valid_d = s0_valid_q;
      s1_frac_d  = s0_frac_q;

      s2_valid_d    = s1_valid_q;
      s2_frac_d     = s1_frac_q;
      s2_sin_base_d = $signed(s1_sin0);
      s2_cos_base_d = $signed(s1_cos0);
      s2_sin_diff_d = DW'($signed(s1_sin1)) - DW'($signed(s1_sin0));
      s2_cos_diff_d = DW'($signed(s1_cos1)) - DW'($signed(s1_cos0));

      s3_valid_d    = s2_valid_q;
      s3_sin_base_d = s2_sin_base_q;
      s3_cos_base_d = s2_cos_base_q;
      s3_sin_prod_d = PW'(s2_sin_diff_q) * PW'($signed({1'b0, s2_frac_q}));
      s3_cos_prod_d = PW'(s2_cos_diff_q) * PW'($signed({1'b0, s2_frac_q}));

      out_valid_d = s3_valid_q;
      out_sin_d   = DATA_W'(sat_data(64'(sin_sum), DATA_W));
      out_cos_d   = DATA_W'(sat_data(64'(cos_sum), DATA_W));
    end
  end

  // Pipeline registers; reset drops every in-flight sample immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid_q <= 1'b0;  sa0_q <= '0;  sa1_q <= '0;  ca0_q <= '0;  ca1_q <= '0;
      s0_frac_q <= '0;
      s1_valid_q <= 1'b0;  s1_frac_q <= '0;
      s2_valid_q <= 1'b0;  s2_frac_q <= '0;
      s2_sin_base_q <= '0;  s2_cos_base_q <= '0;
      s2_sin_diff_q <= '0;  s2_cos_diff_q <= '0;
      s3_valid_q <= 1'b0;
      s3_sin_base_q <= '0;  s3_cos_base_q <= '0;
      s3_sin_prod_q <= '0;  s3_cos_prod_q <= '0;
      out_valid_q <= 1'b0;  out_sin_q <= '0;  out_cos_q <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;  sa0_q <= sa0_d;  sa1_q <= sa1_d;
      ca0_q <= ca0_d;  ca1_q <= ca1_d;  s0_frac_q <= s0_frac_d;
      s1_valid_q <= s1_valid_d;  s1_frac_q <= s1_frac_d;
      s2_valid_q <= s2_valid_d;  s2_frac_q <= s2_frac_d;
      s2_sin_base_q <= s2_sin_base_d;  s2_cos_base_q <= s2_cos_base_d;
      s2_sin_diff_q <= s2_sin_diff_d;  s2_cos_diff_q <= s2_cos_diff_d;
      s3_valid_q <= s3_valid_d;
      s3_sin_base_q <= s3_sin_base_d;  s3_cos_base_q <= s3_cos_base_d;
      s3_sin_prod_q <= s3_sin_prod_d;  s3_cos_prod_q <= s3_cos_prod_d;
      out_valid_q <= out_valid_d;  out_sin_q <= out_sin_d;  out_cos_q <= out_cos_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sin   = out_sin_q;
  assign out_cos   = out_cos_q;

endmodule

// File: tb/tb_sincos_interp_pipe.sv
// Scoreboard bench for sincos_interp_pipe at default parameters.
module tb_sincos_interp_pipe;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_phase;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_sin;
  logic signed [15:0] out_cos;

  always #5 clk = ~clk;

  sincos_interp_pipe #(.PHASE_W(32), .ADDR_W(10), .FRAC_W(6), .DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_phase (in_phase),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sin  (out_sin),
    .out_cos  (out_cos)
  );

  typedef struct {
    logic signed [15:0] s;
    logic signed [15:0] c;
    bit                 lat;
    int unsigned        cyc;
    logic [31:0]        ph;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int unsigned cyc   = 0;
  int          tab[1024];
  int          rdy_mode = 0;  // 0: always 1, 1: 1,0,0,1,0,1 pattern, 2: random, 3: always 0
  int unsigned pat_i = 0;
  bit          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pat_i % 6]; pat_i++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int interp(input int t0, input int t1, input int fr);
    int p, r;
    p = (t1 - t0) * fr;
    r = t0 + ((p + 32) >>> 6);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model(input logic [31:0] ph, output int s, output int c);
    int i, f;
    i = int'(ph[31:22]);
    f = int'(ph[21:16]);
    s = interp(tab[i], tab[(i + 1) % 1024], f);
    c = interp(tab[(i + 256) % 1024], tab[(i + 257) % 1024], f);
  endtask

  // Present one phase, hold it through stalls, log expectation on accept
  task automatic send(input logic [31:0] ph, input int es, input int ec, input bit lat);
    int unsigned w;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_phase = ph;
    #4;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk); #4; w++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready=0 for phase %08h, required 1", ph);
    end else begin
      e.s = 16'(es); e.c = 16'(ec); e.lat = lat; e.cyc = cyc; e.ph = ph;
      sb.push_back(e);
    end
  endtask

  task automatic send_model(input logic [31:0] ph, input bit lat);
    int s, c;
    model(ph, s, c);
    send(ph, s, c, lat);
  endtask

  task automatic idle1();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin @(negedge clk); w++; end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one sample per cycle, just before the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (!reset) begin
        check("in_ready_vs_stall", int'(in_ready), int'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          n_out++;
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_output: sin=%0d cos=%0d, required no output", out_sin, out_cos);
          end else begin
            e = sb.pop_front();
            check($sformatf("sin ph=%08h", e.ph), int'(out_sin), int'(e.s));
            check($sformatf("cos ph=%08h", e.ph), int'(out_cos), int'(e.c));
            if (e.lat) check($sformatf("latency ph=%08h", e.ph), int'(cyc - e.cyc), 5);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int unsigned w;
    real v;
    for (int k = 0; k < 1024; k++) begin
      v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
      tab[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    end

    reset = 1'b1; in_valid = 1'b0; in_phase = '0;
    repeat (3) @(negedge clk);
    #4;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_sin", int'(out_sin), 0);
    check("reset out_cos", int'(out_cos), 0);
    check("reset in_ready", int'(in_ready), 1);
    @(negedge clk); reset = 1'b0;

    // Directed, hand-computed
    send(32'h0000_0000, 0, 32767, 1'b1);   idle1(); wait_drain("zero");
    send(32'h4000_0000, 32767, 0, 1'b1);
    send(32'h8000_0000, 0, -32767, 1'b1);
    send(32'hFFE0_0000, -100, 32767, 1'b1); // idx 1023 wraps: (201*32+32)>>>6 = 101
    send(32'h0020_0000, 101, 32767, 1'b1);
    send(32'h003F_0000, 198, 32766, 1'b1);  // frac = 63
    send(32'h4000_FFFF, 32767, 0, 1'b1);    // sub-fraction LSBs ignored
    idle1(); wait_drain("directed");

    // Backpressure, 1,0,0,1,0,1 pattern
    n0 = n_out;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_model(32'h1234_5678 + 32'(i) * 32'h1F00_3A41, 1'b0);
    idle1(); wait_drain("backpressure");
    rdy_mode = 0;
    repeat (6) @(negedge clk);
    check("backpressure result count", n_out - n0, 8);

    // Reset with samples in flight
    rdy_mode = 3;
    for (int i = 0; i < 3; i++) send_model(32'h2222_0000 + 32'(i) * 32'h0A00_0000, 1'b0);
    idle1();
    w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    check("inflight output present", int'(out_valid), 1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset out_sin", int'(out_sin), 0);
    check("midreset in_ready", int'(in_ready), 1);
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(32'hC000_0000, -32767, 0, 1'b1);
    idle1(); wait_drain("after_reset");
    repeat (8) @(negedge clk);

    // Random sweep with random backpressure and input gaps
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      send_model($urandom(), 1'b0);
      if ($urandom_range(0, 3) == 0) idle1();
    end
    idle1(); wait_drain("sweep");
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    check("scoreboard empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
